uart_rx_os: RTL and testbench
=============================

# uart_rx_os

16x-oversampled UART receiver for the 50 MHz UART/LCD design: 8 data bits, no parity, 1 stop bit, LSB first. It replaces ad-hoc baud-clock sampling with start-bit validation, 3-sample majority voting, stop-bit checking and a one-cycle `data_valid` strobe in the `clk_50M` domain. It is the receiving end for the link driven by the team's UART transmitter, and feeds the LED/LCD consumers.

## Interface
Parameters:
- `MAIN_CLK`, 50_000_000, system clock in Hz
- `UART_CLK`, 9600, baud rate
- `OVERSAMPLE`, 16, samples per bit; fixed at 16 for this revision

Ports:
- `clk_50M`  in  1  system clock; the block's only clock
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk_50M`
- `uart_rx`  in  1  asynchronous serial line, idles high
- `data_out`  out  8  last correctly received byte; holds until the next valid byte
- `data_valid`  out  1  one-cycle pulse when `data_out` updates
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0
- `rx_busy`  out  1  high in any state other than IDLE

## Operation
- Input conditioning: 2-FF synchronizer on `uart_rx` gives `rx_s`.
  - Both flops reset to 1.
  - Line-level decisions use only `rx_s`.
- Tick divider:
  - `DIV = MAIN_CLK/(UART_CLK*OVERSAMPLE)`, integer division (325 at the defaults).
  - The counter runs 0..DIV-1 and asserts `tick` for one cycle at DIV-1.
- Sample counter: `smp` runs 0..15 and advances on `tick`. Bit counter: `bitn` runs 0..7.
- Majority vote:
  - `rx_s` is captured on the ticks where `smp` = 6, 7 and 8.
  - The bit value is the majority of those three samples and is evaluated on the `smp`=8 tick.
- FSM states are IDLE, START, DATA, STOP and BREAK.
  - IDLE: when `rx_s`=0, clear the divider and `smp`, then go to START.
  - START: at the `smp`=8 evaluation:
    - vote=1 means a false start; return to IDLE with no output.
    - vote=0 continues. On `smp`=15 `tick`, go to DATA with `bitn`=0.
  - DATA:
    - At evaluation, write the vote into `shift[bitn]` (LSB first).
    - On `smp`=15 `tick`: if `bitn`=7 go to STOP, otherwise `bitn`+1.
  - STOP: at evaluation:
    - vote=1: load `data_out` with `shift`, pulse `data_valid`, go to IDLE.
    - vote=0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. A break (line held low) yields exactly one `frame_err` and no false bytes.
- STOP returns to IDLE at mid-stop-bit. A start bit that immediately follows a stop bit is therefore detected; back-to-back frames need no idle gap.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `frame_err`=0, `rx_busy`=0, FSM in IDLE, all counters 0, `shift`=0.
- Reset asserted mid-frame:
  - The frame is abandoned. No pulse is emitted on the reset cycle or after it.
  - After release, the receiver waits in IDLE for the next falling edge of `rx_s`.
  - If the line is low at release, that low is treated as a start bit. It normally fails the stop-bit check or resynchronizes.
- Start detect: 2 cycles from the `uart_rx` fall at the pin to `rx_s`=0, plus 1 cycle to enter START.
- `data_valid` and `frame_err`:
  - Each is registered and high for exactly one `clk_50M` cycle, on the cycle after the stop-bit `smp`=8 tick.
  - Nominal latency is about 9.5 bit times after the start edge: ≈ 9.5 × 16 × 325 + 3 cycles.
  - The two pulses are mutually exclusive.
- `rx_busy` rises on the cycle of IDLE→START and falls on the cycle the FSM enters IDLE.
- Tolerance: correct reception for a transmitter baud error of up to ±3%.

## Structure
- The `MAIN_CLK`/`UART_CLK`-derived divisor and the FSM state encodings belong in the shared UART package. The team's transmitter reuses the same divisor function.
- One natural sub-module is `uart_baud_tick`, the divider with a synchronous clear input and a `tick` output, shareable with the transmitter.
- Synchronizer, voter and FSM stay in `uart_rx_os`.

## Test plan
- Reset, then frame 0x55 at 9600 baud: exactly one `data_valid`, `data_out`=0x55, no `frame_err`, `rx_busy` back to 0.
- Back-to-back frames 0xA3, 0x00, 0xFF with no idle gap: three `data_valid` pulses in order, values matching.
- 2 µs low glitch on an idle line: no pulse, `rx_busy` returns to 0 within one bit time, and a following 0x3C is received correctly.
- Frame 0x81 with the stop bit forced to 0, then the line held low for 20 bit times: one `frame_err`, no `data_valid`, `data_out` keeps its previous value, and the next 0x42 is received after the line returns high.
- Single-cycle spike inverted at mid-bit 3 of 0xF0: the majority vote rejects it and `data_out`=0xF0.
- Reset pulsed during bit 4 of 0x99: no pulse, outputs at reset values, and a subsequent 0x66 is received correctly.
- Transmitter clocked at 9600×1.03 and 9600×0.97 sending 0x5A: received correctly in both cases.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: baud divisor helper, majority voter and receiver states.
`timescale 1ns/1ps
package uart_rx_os_pkg;

   // Clock cycles per oversample tick; the transmitter derives its bit clock the same way.
   function automatic int uart_div(input int main_clk, input int baud, input int os);
      return main_clk / (baud * os);
   endfunction

   // Two-out-of-three majority used to filter noise on the sampled line.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// Free-running oversample tick divider with a synchronous clear for realignment.
`timescale 1ns/1ps
module uart_rx_os_baud_tick #(
   parameter int DIV = 325
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Count 0..DIV-1; clear restarts the phase so the first tick lands DIV cycles later.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled 8N1 UART receiver with start validation, majority vote and stop check.
`timescale 1ns/1ps
module uart_rx_os
   import uart_rx_os_pkg::*;
#(
   parameter int MAIN_CLK   = 50_000_000,
   parameter int UART_CLK   = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int DIV = uart_div(MAIN_CLK, UART_CLK, OVERSAMPLE);

   rx_state_t  state, state_n;
   logic       rx_meta, rx_s;
   logic       tick, clr;
   logic [3:0] smp;
   logic [2:0] bitn;
   logic [7:0] shift;
   logic       s6, s7, vote;
   logic       mid_tick, end_tick;
   logic       load, ferr_n;

   uart_rx_os_baud_tick #(.DIV(DIV)) u_tick (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clear   (clr),
      .tick    (tick)
   );

   assign mid_tick = tick && (smp == 4'd8);
   assign end_tick = tick && (smp == 4'd15);
   assign vote     = maj3(s6, s7, rx_s);
   assign rx_busy  = (state != ST_IDLE);

   // Two-flop synchronizer; idles high so reset never looks like a start edge.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   // State register.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and control strobes; decisions are taken at mid-bit or at bit end.
   always_comb begin
      state_n = state;
      clr     = 1'b0;
      load    = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               clr     = 1'b1;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (mid_tick && vote) begin
               state_n = ST_IDLE;
            end else if (end_tick) begin
               state_n = ST_DATA;
            end
         end
         ST_DATA: begin
            if (end_tick && (bitn == 3'd7)) begin
               state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (mid_tick) begin
               if (vote) begin
                  load    = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath: sample counter, vote samples, bit index, shift register and output pulses.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         smp        <= 4'd0;
         bitn       <= 3'd0;
         shift      <= 8'h00;
         s6         <= 1'b1;
         s7         <= 1'b1;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= load;
         frame_err  <= ferr_n;
         if (load) begin
            data_out <= shift;
         end
         if (clr) begin
            smp <= 4'd0;
         end else if (tick && (state != ST_IDLE)) begin
            smp <= smp + 1'b1;
         end
         if (tick && (smp == 4'd6)) begin
            s6 <= rx_s;
         end
         if (tick && (smp == 4'd7)) begin
            s7 <= rx_s;
         end
         if ((state == ST_START) && (state_n == ST_DATA)) begin
            bitn <= 3'd0;
         end else if ((state == ST_DATA) && end_tick) begin
            bitn <= bitn + 1'b1;
         end
         if ((state == ST_DATA) && mid_tick) begin
            shift[bitn] <= vote;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames, glitches, breaks, reset and baud skew.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int  MAIN_CLK = 50_000_000;
   localparam int  UART_CLK = 312_500;
   localparam real BIT_NS   = 3200.0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   logic       clk_50M = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       rx_busy;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic dv_prev = 1'b0;
   logic fe_prev = 1'b0;

   uart_rx_os #(
      .MAIN_CLK   (MAIN_CLK),
      .UART_CLK   (UART_CLK),
      .OVERSAMPLE (16)
   ) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .uart_rx    (uart_rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   // 50 MHz system clock.
   always #10 clk_50M = ~clk_50M;

   // One scored comparison.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
      end
   endtask

   // Drive one 8N1 frame; stop_val selects the stop level and spike_bit inverts one cycle at mid-bit.
   task automatic applyStimulus(input logic [7:0] d, input real bit_ns, input logic stop_val, input int spike_bit);
      uart_rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         if (i == spike_bit) begin
            #(bit_ns / 2.0);
            uart_rx = ~d[i];
            #(20);
            uart_rx = d[i];
            #(bit_ns / 2.0 - 20.0);
         end else begin
            #(bit_ns);
         end
      end
      uart_rx = stop_val;
      #(bit_ns);
   endtask

   // Queue an expected good byte and send it.
   task automatic sendByte(input logic [7:0] d, input real bit_ns);
      exp_t e;
      e.is_err = 1'b0;
      e.data   = d;
      exp_q.push_back(e);
      applyStimulus(d, bit_ns, 1'b1, -1);
   endtask

   // Wait for every expected pulse to be consumed, bounded by a cycle budget.
   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk_50M);
         n++;
      end
      checkOutput(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: pop and compare on every output pulse, and police pulse width and exclusivity.
   always @(negedge clk_50M) begin
      if (data_valid) checkOutput("dv_width", dv_prev, 0);
      if (frame_err)  checkOutput("fe_width", fe_prev, 0);
      if (data_valid || frame_err) begin
         checkOutput("pulse_exclusive", data_valid & frame_err, 0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", {data_valid, frame_err}, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("pulse_kind", frame_err, e.is_err);
            if (!e.is_err) checkOutput("data_out", data_out, e.data);
         end
      end
      dv_prev <= data_valid;
      fe_prev <= frame_err;
   end

   // Watchdog so the run always terminates.
   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      exp_t e;
      uart_rx = 1'b1;
      rst_n   = 1'b0;
      repeat (5) @(negedge clk_50M);
      checkOutput("rst_data_out", data_out, 8'h00);
      checkOutput("rst_data_valid", data_valid, 0);
      checkOutput("rst_frame_err", frame_err, 0);
      checkOutput("rst_rx_busy", rx_busy, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk_50M);

      // Single frame.
      sendByte(8'h55, BIT_NS);
      waitDrain("drain_55", 400);
      repeat (10) @(negedge clk_50M);
      checkOutput("busy_after_55", rx_busy, 0);

      // Back-to-back frames with no idle gap.
      sendByte(8'hA3, BIT_NS);
      sendByte(8'h00, BIT_NS);
      sendByte(8'hFF, BIT_NS);
      waitDrain("drain_b2b", 400);
      repeat (100) @(negedge clk_50M);

      // Short low glitch on an idle line.
      @(negedge clk_50M);
      uart_rx = 1'b0;
      repeat (3) @(negedge clk_50M);
      uart_rx = 1'b1;
      repeat (5) @(negedge clk_50M);
      checkOutput("glitch_busy_high", rx_busy, 1);
      #(BIT_NS);
      checkOutput("glitch_busy_low", rx_busy, 0);
      sendByte(8'h3C, BIT_NS);
      waitDrain("drain_3C", 400);

      // Stop bit forced low followed by a long break.
      e.is_err = 1'b1;
      e.data   = 8'h00;
      exp_q.push_back(e);
      applyStimulus(8'h81, BIT_NS, 1'b0, -1);
      waitDrain("drain_ferr", 400);
      checkOutput("hold_after_ferr", data_out, 8'h3C);
      #(BIT_NS * 20.0);
      checkOutput("busy_in_break", rx_busy, 1);
      uart_rx = 1'b1;
      #(BIT_NS * 2.0);
      checkOutput("busy_after_break", rx_busy, 0);
      checkOutput("hold_after_break", data_out, 8'h3C);
      sendByte(8'h42, BIT_NS);
      waitDrain("drain_42", 400);
      repeat (100) @(negedge clk_50M);

      // One-cycle spike at mid-bit 3.
      e.is_err = 1'b0;
      e.data   = 8'hF0;
      exp_q.push_back(e);
      applyStimulus(8'hF0, BIT_NS, 1'b1, 3);
      waitDrain("drain_F0", 400);
      repeat (100) @(negedge clk_50M);

      // Reset in the middle of bit 4 of 0x99, line then returned to idle.
      uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         uart_rx = (i == 0 || i == 3) ? 1'b1 : 1'b0;
         #(BIT_NS);
      end
      uart_rx = 1'b1;
      #(BIT_NS / 2.0);
      @(negedge clk_50M);
      rst_n = 1'b0;
      repeat (3) @(negedge clk_50M);
      checkOutput("midrst_data_out", data_out, 8'h00);
      checkOutput("midrst_busy", rx_busy, 0);
      rst_n = 1'b1;
      #(BIT_NS * 6.0);
      checkOutput("postrst_data_out", data_out, 8'h00);
      checkOutput("postrst_busy", rx_busy, 0);
      sendByte(8'h66, BIT_NS);
      waitDrain("drain_66", 400);
      repeat (100) @(negedge clk_50M);

      // Transmitter baud error of +3% and -3%.
      sendByte(8'h5A, BIT_NS / 1.03);
      waitDrain("drain_5A_fast", 400);
      repeat (100) @(negedge clk_50M);
      sendByte(8'h5A, BIT_NS / 0.97);
      waitDrain("drain_5A_slow", 400);
      repeat (100) @(negedge clk_50M);
      checkOutput("final_busy", rx_busy, 0);
      checkOutput("final_data_out", data_out, 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
